// File: rtl/psum_ofifo_pkg.sv
// Shared constants, the lane word type and the pointer-width helper for the
// psum output FIFO between the MAC array columns and the SFU.
package psum_ofifo_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 64;

  typedef logic [PSUM_BW-1:0] psum_word_t;

  // Pointer width: one extra MSB beyond the address bits to tell full from empty.
  function automatic int ptr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/psum_lane_fifo.sv
// Single-lane first-word-fall-through circular buffer. The head entry is
// always visible on dout; pointers carry one wrap bit so equal pointers mean
// empty and equal address bits with differing MSBs mean full.
module psum_lane_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int PW = ptr_width(depth);
  localparam int AW = PW - 1;

  logic [psum_bw-1:0] mem_r [depth];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);

  // A pop on a full lane frees the head slot in the same edge, so the push may land.
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);

  assign dout = mem_r[rd_ptr_r[AW-1:0]];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // Pointer advance; wraps naturally modulo 2*depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO between the MAC array columns and the SFU. Each column pushes
// into its own lane; a row is presented only when every lane holds data and
// pops always remove one entry from every lane, keeping rows aligned.
// Optional build macro PSUM_OFIFO_ERR_EN adds a sticky o_err flag for dropped
// pushes and pops requested while no row is available.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr_i,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic                   rd_i,
  output logic [col*psum_bw-1:0] psum_out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef PSUM_OFIFO_ERR_EN
  ,
  output logic                   o_err
`endif
);

  logic [col-1:0]         empty_s;
  logic [col-1:0]         full_s;
  logic [col*psum_bw-1:0] head_s;
  logic                   valid_s;
  logic                   pop_s;

  for (genvar c = 0; c < col; c++) begin : g_lane
    psum_lane_fifo #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (wr_i[c]),
      .pop   (pop_s),
      .din   (psum_in[c*psum_bw +: psum_bw]),
      .dout  (head_s[c*psum_bw +: psum_bw]),
      .empty (empty_s[c]),
      .full  (full_s[c])
    );
  end

  assign valid_s = ~|empty_s;
  assign pop_s   = rd_i & valid_s;

  assign o_valid = valid_s;
  assign o_full  = |full_s;
  assign o_ready = ~|full_s;

  // Zero the output bus whenever no complete row exists so stale storage never leaks.
  always_comb begin
    psum_out = {(col*psum_bw){1'b0}};
    if (valid_s) begin
      psum_out = head_s;
    end else begin
      psum_out = {(col*psum_bw){1'b0}};
    end
  end

`ifdef PSUM_OFIFO_ERR_EN
  logic err_r;
  logic drop_s;
  logic bad_pop_s;

  assign drop_s    = (|(wr_i & full_s)) & ~pop_s;
  assign bad_pop_s = rd_i & ~valid_s;
  assign o_err     = err_r;

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (drop_s | bad_pop_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: a lane-queue reference model assembles
// expected rows as stimulus is issued; a negedge monitor compares every
// presented head row and every popped row against the expected-row queue.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int W = COL * PSUM_BW;

  logic           clk     = 1'b0;
  logic           reset   = 1'b0;
  logic [COL-1:0] wr_i    = '0;
  logic [W-1:0]   psum_in = '0;
  logic           rd_i    = 1'b0;
  logic [W-1:0]   psum_out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
`ifdef PSUM_OFIFO_ERR_EN
  logic           o_err;
`endif

  psum_ofifo #(.col(COL), .psum_bw(PSUM_BW), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_i     (wr_i),
    .psum_in  (psum_in),
    .rd_i     (rd_i),
    .psum_out (psum_out),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_ready  (o_ready)
`ifdef PSUM_OFIFO_ERR_EN
    ,
    .o_err    (o_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-lane occupancy, words not yet formed into rows, expected rows.
  int         cnt [COL];
  psum_word_t lane_q [COL][$];
  logic [W-1:0] exp_q [$];
  logic       err_m = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < COL; c++) begin
      cnt[c] = 0;
      lane_q[c].delete();
    end
    exp_q.delete();
    err_m = 1'b0;
  endtask

  // Apply the effect of one clock edge with the given inputs to the model.
  task automatic model_step(input logic [COL-1:0] wr, input logic [W-1:0] data, input logic rd);
    bit pop_ok = rd;
    bit all_have;
    logic [W-1:0] row;
    for (int c = 0; c < COL; c++) if (cnt[c] == 0) pop_ok = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (wr[c]) begin
        if (cnt[c] < DEPTH || pop_ok) begin
          lane_q[c].push_back(data[c*PSUM_BW +: PSUM_BW]);
          cnt[c]++;
        end else begin
          err_m = 1'b1;
        end
      end
    end
    if (rd && !pop_ok) err_m = 1'b1;
    if (pop_ok) for (int c = 0; c < COL; c++) cnt[c]--;
    forever begin
      all_have = 1'b1;
      for (int c = 0; c < COL; c++) if (lane_q[c].size() == 0) all_have = 1'b0;
      if (!all_have) break;
      for (int c = 0; c < COL; c++) row[c*PSUM_BW +: PSUM_BW] = lane_q[c].pop_front();
      exp_q.push_back(row);
    end
  endtask

  task automatic chk_flags();
    bit ev = 1'b1;
    bit ef = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (cnt[c] == 0) ev = 1'b0;
      if (cnt[c] == DEPTH) ef = 1'b1;
    end
    chk1("o_valid", o_valid, ev);
    chk1("o_full", o_full, ef);
    chk1("o_ready", o_ready, ~ef);
`ifdef PSUM_OFIFO_ERR_EN
    chk1("o_err", o_err, err_m);
`endif
  endtask

  // One cycle: check state left by the previous edge, then drive the next edge's inputs.
  task automatic cyc(input logic [COL-1:0] wr, input logic [W-1:0] data, input logic rd);
    @(posedge clk);
    #2;
    chk_flags();
    wr_i    = wr;
    psum_in = data;
    rd_i    = rd;
    model_step(wr, data, rd);
  endtask

  task automatic idle();
    cyc('0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom());
    return r;
  endfunction

  // Monitor: every presented row must match the oldest expected row; popped rows retire it.
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL row_present: got %h expected no row at %0t", psum_out, $time);
      end else begin
        chkw("row_head", psum_out, exp_q[0]);
        if (rd_i && reset) void'(exp_q.pop_front());
      end
    end else begin
      chkw("row_zero", psum_out, '0);
    end
  end

  initial begin
    logic [W-1:0] row;
    psum_word_t   w;
    logic [COL-1:0] wm;

    // 1. Reset then idle
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_full", o_full, 1'b0);
    chk1("rst_ready", o_ready, 1'b1);
    chkw("rst_psum", psum_out, '0);

    // 2. Skewed fill
    row = '0;
    for (int c = 0; c < 7; c++) row[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(c + 1);
    cyc(8'h7F, row, 1'b0);
    idle();
    chk1("skew_valid_a", o_valid, 1'b0);
    idle();
    chk1("skew_valid_b", o_valid, 1'b0);
    row = '0;
    row[7*PSUM_BW +: PSUM_BW] = 16'h0008;
    cyc(8'h80, row, 1'b0);
    idle();
    chk1("skew_valid_c", o_valid, 1'b1);
    row = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    chkw("skew_row", psum_out, row);

    // 3. Row pop, then an ignored pop
    cyc('0, '0, 1'b1);
    idle();
    chk1("pop_valid", o_valid, 1'b0);
    chkw("pop_psum", psum_out, '0);
    cyc('0, '0, 1'b1);
    idle();
    chk1("ign_valid", o_valid, 1'b0);
    chk1("ign_ready", o_ready, 1'b1);
`ifdef PSUM_OFIFO_ERR_EN
    chk1("ign_err", o_err, 1'b1);
`endif

    // 4. Full, dropped push, and wrap
    for (int i = 0; i < DEPTH; i++) begin
      w = psum_word_t'(i);
      cyc(8'hFF, {COL{w}}, 1'b0);
    end
    idle();
    chk1("full_full", o_full, 1'b1);
    chk1("full_ready", o_ready, 1'b0);
    w = 16'hFFFF;
    cyc(8'hFF, {COL{w}}, 1'b0);
    idle();
    chk1("drop_full", o_full, 1'b1);
    w = 16'h0000;
    chkw("drop_head", psum_out, {COL{w}});
    for (int i = 0; i < DEPTH; i++) cyc('0, '0, 1'b1);
    idle();
    chk1("drain_valid", o_valid, 1'b0);

    // 5. Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      w = psum_word_t'(i);
      cyc(8'hFF, {COL{w}}, 1'b0);
    end
    w = 16'h0040;
    cyc(8'hFF, {COL{w}}, 1'b1);
    idle();
    chk1("pp_full", o_full, 1'b1);
    w = 16'h0001;
    chkw("pp_head", psum_out, {COL{w}});
    for (int i = 0; i < DEPTH - 1; i++) cyc('0, '0, 1'b1);
    idle();
    w = 16'h0040;
    chkw("pp_last", psum_out, {COL{w}});
    cyc('0, '0, 1'b1);
    idle();
    chk1("pp_empty", o_valid, 1'b0);

    // 6. Mid-operation asynchronous reset
    for (int i = 0; i < 10; i++) cyc(8'hFF, rand_row(), 1'b0);
    idle();
    chk1("pre_rst_valid", o_valid, 1'b1);
    #1;
    reset = 1'b0;
    wr_i  = '0;
    rd_i  = 1'b0;
    model_clear();
    #1;
    chk1("arst_valid", o_valid, 1'b0);
    chkw("arst_psum", psum_out, '0);
    chk1("arst_full", o_full, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    row = rand_row();
    cyc(8'hFF, row, 1'b0);
    idle();
    chk1("fresh_valid", o_valid, 1'b1);
    chkw("fresh_row", psum_out, row);
    cyc('0, '0, 1'b1);
    idle();

    // Randomized traffic: push-heavy phase reaches full, pop-heavy phase drains.
    for (int i = 0; i < 3000; i++) begin
      wm = COL'($urandom());
      if (i < 1500) cyc(wm, rand_row(), ($urandom_range(0, 3) == 0));
      else          cyc(wm & COL'($urandom()), rand_row(), ($urandom_range(0, 3) != 0));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output FIFO between the MAC array columns and the SFU.
- Each of the col columns pushes psum words independently as they drain from the array.
- A row is presented as one col*psum_bw word only when every column holds data.
- Downstream logic pops whole rows and drives them onto the SFU psum_in bus.

Parameters:
col, 8, number of array columns / independent lanes
psum_bw, 16, width of one psum word
depth, 64, entries per lane; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all pointers and flags
wr_i  input  col  per-lane push strobe; bit c pushes lane c
psum_in  input  col*psum_bw  per-lane write data; lane c at bits [psum_bw*(c+1)-1 : psum_bw*c]
rd_i  input  1  pop one row (all lanes) when o_valid=1
psum_out  output  col*psum_bw  head row, first-word-fall-through; same lane packing as psum_in
o_valid  output  1  all lanes non-empty
o_full  output  1  any lane full
o_ready  output  1  no lane full; upstream pushes only when high

Behaviour:
- Storage: col independent circular buffers, depth entries each.
- Pointers: per-lane write/read pointers, log2(depth)+1 bits. The MSB distinguishes full from empty.
  - empty: pointers equal.
  - full: low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*depth.
- Reset (reset low, asynchronous):
  - All pointers become 0.
  - o_valid=0, o_full=0, o_ready=1, psum_out=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all queued data immediately.
- Push:
  - On a rising edge with wr_i[c]=1, lane c stores psum_in lane c and increments its write pointer.
  - A push to a full lane is dropped (pointer unchanged), except when a pop is accepted in the same cycle; then the push is accepted and occupancy is unchanged.
- Pop:
  - Accepted when rd_i=1 and o_valid=1; every lane's read pointer increments by one.
  - rd_i while o_valid=0 is ignored; no pointer moves.
- Simultaneous push and pop on a non-empty lane: both take effect, occupancy unchanged.
- Simultaneous push and pop on an empty lane cannot occur, because o_valid=0 blocks the pop.
- Flags (combinational from registered pointers):
  - o_valid = AND over lanes of non-empty.
  - o_full = OR over lanes of full.
  - o_ready = ~o_full.
- Latency:
  - A push at edge N is readable after edge N; o_valid can rise in the cycle following edge N.
  - A pop at edge N exposes the next row after edge N.
- psum_out:
  - Equals the head entry of each lane when o_valid=1.
  - Forced to all zeros when o_valid=0, so the SFU never sees stale storage.
- Lane skew: lanes may differ in occupancy by any amount. Rows stay aligned because pops are always all-lane.
- No arithmetic is performed; data passes through bit-exact.

Optional Feature:
PSUM_OFIFO_ERR_EN
- Defined:
  - Adds output port o_err (1 bit).
  - o_err is a sticky flag, set on any dropped push (push to a full lane without a same-cycle pop).
  - o_err is also set on rd_i=1 while o_valid=0.
  - o_err is cleared only by reset.
- Undefined: no o_err port and no error logic. Dropped pushes and ignored pops are silent.

Decomposition:
- Shared package:
  - PSUM_BW and COL default constants.
  - Helper function for pointer width, log2(depth)+1.
  - Typedef for one psum lane word.
- One natural sub-module: psum_lane_fifo.
  - Single-lane FWFT circular buffer with push, pop, empty and full.
  - Instantiated col times by a generate loop.
  - The top level does the flag reduction, pop gating, output zeroing and the optional error flag.

Test Plan:
1. Reset then idle:
   - Hold reset low 2 cycles, release.
   - Expect o_valid=0, o_full=0, o_ready=1, psum_out=0.
2. Skewed fill:
   - Push lanes 0..6 with 16'h0001..16'h0007, then lane 7 with 16'h0008 two cycles later.
   - Expect o_valid to rise only after the lane-7 push.
   - Expect psum_out = 128'h0008_0007_0006_0005_0004_0003_0002_0001.
3. Row pop:
   - After scenario 2, pulse rd_i one cycle.
   - Expect o_valid=0 and psum_out=0 next cycle.
   - A further rd_i changes nothing (and sets o_err with PSUM_OFIFO_ERR_EN).
4. Full and wrap:
   - Push 64 words 16'h0000..16'h003F to all lanes.
   - Expect o_full=1, o_ready=0.
   - Push 16'hFFFF with no pop: dropped; o_err=1 if enabled.
   - Pop 64 rows: each row has all lanes equal to 0..63 in order.
   - After the final pop, o_valid=0.
5. Full with simultaneous push and pop:
   - With all lanes full, assert wr_i=8'hFF with data 16'h0040 and rd_i=1 for one cycle.
   - Expect o_full to stay 1.
   - The head advances to 16'h0001; after 63 more pops, the last row is 16'h0040.
6. Mid-operation reset:
   - Fill 10 rows, assert reset asynchronously between clock edges.
   - Expect o_valid=0 and psum_out=0 immediately, without waiting for an edge.
   - After release, a fresh row is read back correctly.
